// File: rtl/exec_mem_latch.sv
// EX/MEM pipeline register: latches exec2 results for the mem stage, pulses taken
// branches to fetch and turns ALU overflow into a held exception until acked.
module exec_mem_latch #(
  parameter int REG_SIZE  = 32,
  parameter int ADDR_SIZE = 32,
  parameter int DST_W     = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [REG_SIZE-1:0]  pre_aluresult,
  input  logic                 pre_zero,
  input  logic                 pre_overflow,
  input  logic [ADDR_SIZE-1:0] pre_new_pc,
  input  logic [DST_W-1:0]     pre_dst,
  input  logic [REG_SIZE-1:0]  pre_store_data,
  input  logic                 pre_is_branch,
  input  logic                 pre_reg_write,
  input  logic                 pre_mem_read,
  input  logic                 pre_mem_write,
  input  logic                 exc_ack,
  output logic                 out_valid,
  output logic [REG_SIZE-1:0]  aluresult,
  output logic [REG_SIZE-1:0]  store_data,
  output logic [DST_W-1:0]     dst,
  output logic                 reg_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 branch_taken,
  output logic [ADDR_SIZE-1:0] branch_target,
  output logic                 exc_valid,
  output logic [ADDR_SIZE-1:0] exc_pc,
  output logic                 hold_upstream
);

  // state | meaning
  // RUN   | normal pipelining: flush > stall > load each edge
  // EXC   | overflow pending: contents frozen, upstream held until exc_ack
  typedef enum logic {RUN = 1'b0, EXC = 1'b1} state_t;

  state_t state_q, state_d;
  logic   do_load;
  logic   exc_hit;
  logic   keep;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    do_load       = 1'b0;
    exc_hit       = 1'b0;
    hold_upstream = 1'b0;
    case (state_q)
      RUN: begin
        do_load = ~flush & ~stall;
        exc_hit = do_load & in_valid & pre_overflow;
        if (exc_hit) state_d = EXC;
      end
      EXC: begin
        hold_upstream = 1'b1;
        if (exc_ack) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // An instruction that overflows is squashed: it never reaches mem as valid.
  assign keep = in_valid & ~pre_overflow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid     <= 1'b0;
      aluresult     <= '0;
      store_data    <= '0;
      dst           <= '0;
      reg_write     <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      branch_taken  <= 1'b0;
      branch_target <= '0;
      exc_valid     <= 1'b0;
      exc_pc        <= '0;
    end else if (state_q == EXC) begin
      if (exc_ack) begin
        exc_valid <= 1'b0;
        out_valid <= 1'b0;
      end
    end else if (flush) begin
      out_valid    <= 1'b0;
      reg_write    <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      branch_taken <= 1'b0;
    end else if (stall) begin
      branch_taken <= 1'b0;
    end else if (do_load) begin
      aluresult     <= pre_aluresult;
      store_data    <= pre_store_data;
      dst           <= pre_dst;
      branch_target <= pre_new_pc;
      out_valid     <= keep;
      reg_write     <= keep & pre_reg_write;
      mem_read      <= keep & pre_mem_read;
      mem_write     <= keep & pre_mem_write;
      branch_taken  <= keep & pre_is_branch & pre_zero;
      if (exc_hit) begin
        exc_valid <= 1'b1;
        exc_pc    <= pre_new_pc;
      end
    end
  end

endmodule

// File: tb/tb_exec_mem_latch.sv
// Directed + random bench for exec_mem_latch against a cycle-level reference
// model derived from the pipeline-register rules.
module tb_exec_mem_latch;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, stall, flush;
  logic [31:0] pre_aluresult, pre_new_pc, pre_store_data;
  logic        pre_zero, pre_overflow, pre_is_branch;
  logic [4:0]  pre_dst;
  logic        pre_reg_write, pre_mem_read, pre_mem_write, exc_ack;

  logic        out_valid, reg_write, mem_read, mem_write, branch_taken;
  logic [31:0] aluresult, store_data, branch_target, exc_pc;
  logic [4:0]  dst;
  logic        exc_valid, hold_upstream;

  int errors = 0;
  int checks = 0;

  exec_mem_latch dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .pre_aluresult(pre_aluresult), .pre_zero(pre_zero), .pre_overflow(pre_overflow),
    .pre_new_pc(pre_new_pc), .pre_dst(pre_dst), .pre_store_data(pre_store_data),
    .pre_is_branch(pre_is_branch), .pre_reg_write(pre_reg_write),
    .pre_mem_read(pre_mem_read), .pre_mem_write(pre_mem_write), .exc_ack(exc_ack),
    .out_valid(out_valid), .aluresult(aluresult), .store_data(store_data), .dst(dst),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .exc_valid(exc_valid), .exc_pc(exc_pc), .hold_upstream(hold_upstream)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ov, rw, mr, mw, bt, ev;
    logic [31:0] alu, sd, bta, epc;
    logic [4:0]  dst;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.ov = 0; r.rw = 0; r.mr = 0; r.mw = 0; r.bt = 0; r.ev = 0;
    r.alu = 0; r.sd = 0; r.bta = 0; r.epc = 0; r.dst = 0;
    return r;
  endfunction

  // What the mem stage should hold after the coming edge.
  function automatic model_t model_next(model_t c);
    model_t n = c;
    bit real_instr, faults;
    if (c.ev) begin
      if (exc_ack) begin n.ev = 0; n.ov = 0; end
      return n;
    end
    if (flush) begin
      n.ov = 0; n.rw = 0; n.mr = 0; n.mw = 0; n.bt = 0;
      return n;
    end
    if (stall) begin
      n.bt = 0;
      return n;
    end
    faults     = in_valid && pre_overflow;
    real_instr = in_valid && !pre_overflow;
    n.alu = pre_aluresult; n.sd = pre_store_data; n.dst = pre_dst; n.bta = pre_new_pc;
    n.ov  = real_instr;
    n.rw  = real_instr && pre_reg_write;
    n.mr  = real_instr && pre_mem_read;
    n.mw  = real_instr && pre_mem_write;
    n.bt  = real_instr && pre_is_branch && pre_zero;
    if (faults) begin n.ev = 1; n.epc = pre_new_pc; end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".out_valid"},     32'(out_valid),     32'(m.ov));
    chk({ctx, ".aluresult"},     aluresult,          m.alu);
    chk({ctx, ".store_data"},    store_data,         m.sd);
    chk({ctx, ".dst"},           32'(dst),           32'(m.dst));
    chk({ctx, ".reg_write"},     32'(reg_write),     32'(m.rw));
    chk({ctx, ".mem_read"},      32'(mem_read),      32'(m.mr));
    chk({ctx, ".mem_write"},     32'(mem_write),     32'(m.mw));
    chk({ctx, ".branch_taken"},  32'(branch_taken),  32'(m.bt));
    chk({ctx, ".branch_target"}, branch_target,      m.bta);
    chk({ctx, ".exc_valid"},     32'(exc_valid),     32'(m.ev));
    chk({ctx, ".exc_pc"},        exc_pc,             m.epc);
    chk({ctx, ".hold_upstream"}, 32'(hold_upstream), 32'(m.ev));
  endtask

  task automatic tick(input string ctx);
    model_t n = model_next(m);
    @(posedge clk);
    #1;
    m = n;
    check_all(ctx);
  endtask

  task automatic bubble();
    in_valid = 0; stall = 0; flush = 0; exc_ack = 0;
    pre_aluresult = 0; pre_zero = 0; pre_overflow = 0; pre_new_pc = 0;
    pre_dst = 0; pre_store_data = 0; pre_is_branch = 0;
    pre_reg_write = 0; pre_mem_read = 0; pre_mem_write = 0;
  endtask

  initial begin
    reset = 1;
    bubble();
    m = model_reset();
    #1 check_all("reset");
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // normal load
    in_valid = 1; pre_aluresult = 32'hDEADBEEF; pre_dst = 5; pre_reg_write = 1;
    pre_store_data = 32'h11112222; pre_new_pc = 32'h10;
    tick("load");
    chk("load.dst_lit", 32'(dst), 32'd5);
    chk("load.alu_lit", aluresult, 32'hDEADBEEF);
    chk("load.rw_lit", 32'(reg_write), 32'd1);

    // taken branch pulses exactly once
    bubble(); in_valid = 1; pre_is_branch = 1; pre_zero = 1; pre_new_pc = 32'h40;
    tick("br_taken");
    chk("br.pulse_lit", 32'(branch_taken), 32'd1);
    chk("br.target_lit", branch_target, 32'h40);
    bubble();
    tick("br_after");
    chk("br.fall_lit", 32'(branch_taken), 32'd0);
    in_valid = 1; pre_is_branch = 1; pre_zero = 0; pre_new_pc = 32'h44;
    tick("br_not_taken");

    // stall holds, no re-pulse; stall+flush squashes
    bubble(); in_valid = 1; pre_dst = 3; pre_is_branch = 1; pre_zero = 1;
    pre_mem_write = 1; pre_new_pc = 32'h60;
    tick("pre_stall");
    bubble(); stall = 1; pre_dst = 9; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      chk("stall.dst_lit", 32'(dst), 32'd3);
      chk("stall.bt_lit", 32'(branch_taken), 32'd0);
    end
    flush = 1;
    tick("stall_flush");
    chk("flush.valid_lit", 32'(out_valid), 32'd0);

    // overflow freezes until ack; flush/stall ignored meanwhile
    bubble(); in_valid = 1; pre_overflow = 1; pre_new_pc = 32'h80; pre_reg_write = 1;
    pre_aluresult = 32'h7FFFFFFF;
    tick("ovf");
    chk("ovf.ev_lit", 32'(exc_valid), 32'd1);
    chk("ovf.pc_lit", exc_pc, 32'h80);
    chk("ovf.rw_lit", 32'(reg_write), 32'd0);
    chk("ovf.hold_lit", 32'(hold_upstream), 32'd1);
    bubble(); in_valid = 1; pre_reg_write = 1; pre_aluresult = 32'hAAAA5555;
    flush = 1;
    tick("exc_flush");
    flush = 0; stall = 1;
    tick("exc_stall");
    stall = 0;
    tick("exc_wait");
    exc_ack = 1;
    tick("exc_ack");
    chk("ack.hold_lit", 32'(hold_upstream), 32'd0);
    exc_ack = 0;
    tick("post_ack_load");
    chk("post_ack.valid_lit", 32'(out_valid), 32'd1);

    // ack while running is ignored
    exc_ack = 1; pre_dst = 7;
    tick("ack_in_run");
    chk("ack_run.ev_lit", 32'(exc_valid), 32'd0);

    // reset between edges with a branch being loaded
    bubble(); in_valid = 1; pre_aluresult = 32'h1234; pre_is_branch = 1; pre_zero = 1;
    pre_reg_write = 1;
    @(posedge clk);
    #3 reset = 1;
    #1 m = model_reset();
    check_all("reset_mid");
    @(posedge clk);
    #1 check_all("reset_held");
    bubble();
    reset = 0;
    tick("after_reset");
    chk("after_reset.bt_lit", 32'(branch_taken), 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid       = ($urandom_range(0, 3) != 0);
      stall          = ($urandom_range(0, 5) == 0);
      flush          = ($urandom_range(0, 7) == 0);
      exc_ack        = ($urandom_range(0, 2) == 0);
      pre_overflow   = ($urandom_range(0, 9) == 0);
      pre_zero       = 1'($urandom);
      pre_is_branch  = 1'($urandom);
      pre_reg_write  = 1'($urandom);
      pre_mem_read   = 1'($urandom);
      pre_mem_write  = 1'($urandom);
      pre_aluresult  = $urandom;
      pre_store_data = $urandom;
      pre_new_pc     = $urandom;
      pre_dst        = 5'($urandom);
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
